iir_pair_serializer: RTL and testbench

Parallel-to-serial converter at the output side of the 2-parallel unfolded IIR filter. It accepts one output pair per handshake: even sample y[2k] and odd sample y[2k+1]. It buffers pairs in a small FIFO and emits them as a single-rate sample stream, even sample first, with valid/ready flow control on both sides. It sits between the unfolded filter and any single-rate consumer, such as a DAC interface or a folded downstream stage.

---
 rtl/iir_pair_serializer_pkg.sv | 24 ++
 rtl/iir_pair_fifo.sv | 71 +++++++
 rtl/iir_pair_serializer.sv | 137 +++++++++++++
 tb/tb_iir_pair_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pair_serializer_pkg.sv
// Shared definitions for the 2-parallel IIR output serializer: default widths,
// output FSM state encodings and the pair packing order.
package iir_pair_serializer_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CW    = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_EVEN  = 2'd1,
        ST_ODD   = 2'd2
    } ser_state_e;

    // A pair is packed {odd, even}: the even sample occupies the low half.
    function automatic int evenLsb(input int dw);
        return 0 * dw;
    endfunction

    function automatic int oddLsb(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/iir_pair_fifo.sv
// Synchronous FIFO of packed sample pairs; rdata always shows the current head
// so the consumer can read and pop in the same cycle.
module iir_pair_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/iir_pair_serializer.sv
// Output side of the 2-parallel unfolded IIR: buffers {odd, even} pairs and
// emits them as one sample per handshake, even sample first.
module iir_pair_serializer
    import iir_pair_serializer_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = DEFAULT_CW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              y_even,
    input  logic [DW-1:0]              y_odd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic                       out_phase,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CW-1:0]              pair_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EL = evenLsb(DW);
    localparam int OL = oddLsb(DW);

    ser_state_e       state_q, state_d;
    logic [2*DW-1:0]  pair_q, pair_d;
    logic [DW-1:0]    data_q, data_d;
    logic             phase_q, phase_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [2*DW-1:0]  fifo_rdata;
    logic [LW-1:0]    fifo_level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    iir_pair_fifo #(
        .WIDTH (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({y_odd, y_even}),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pops depend only on registered FIFO state, so a same-cycle push into an
    // empty FIFO is never popped until the following edge.
    always_comb begin
        state_d  = state_q;
        pair_d   = pair_q;
        data_d   = data_q;
        phase_d  = phase_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_EVEN;
                    pair_d   = fifo_rdata;
                    data_d   = fifo_rdata[EL +: DW];
                    phase_d  = 1'b0;
                    valid_d  = 1'b1;
                end
            end
            ST_EVEN: begin
                if (out_ready) begin
                    state_d = ST_ODD;
                    data_d  = pair_q[OL +: DW];
                    phase_d = 1'b1;
                end
            end
            ST_ODD: begin
                if (out_ready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_EVEN;
                        pair_d   = fifo_rdata;
                        data_d   = fifo_rdata[EL +: DW];
                        phase_d  = 1'b0;
                        valid_d  = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                        phase_d = 1'b0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
                phase_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            pair_q  <= '0;
            data_q  <= '0;
            phase_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            data_q  <= data_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_phase = phase_q;
    assign level     = fifo_level;
    assign pair_cnt  = cnt_q;

endmodule

// File: tb/tb_iir_pair_serializer.sv
// Directed bench for iir_pair_serializer: a default instance (CW=16) and a
// CW=4 instance share the same stimulus so the counter wrap can be observed.
module tb_iir_pair_serializer;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [7:0]  yEven;
    logic [7:0]  yOdd;
    logic        outReady;

    logic        inReady;
    logic        outValid;
    logic [7:0]  outData;
    logic        outPhase;
    logic [2:0]  level;
    logic [15:0] pairCnt;

    logic        inReady4;
    logic        outValid4;
    logic [7:0]  outData4;
    logic        outPhase4;
    logic [2:0]  level4;
    logic [3:0]  pairCnt4;

    int checks   = 0;
    int failures = 0;

    iir_pair_serializer #(.DW(8), .DEPTH(4), .CW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .y_even    (yEven),
        .y_odd     (yOdd),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_phase (outPhase),
        .level     (level),
        .pair_cnt  (pairCnt)
    );

    iir_pair_serializer #(.DW(8), .DEPTH(4), .CW(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady4),
        .y_even    (yEven),
        .y_odd     (yOdd),
        .out_valid (outValid4),
        .out_ready (outReady),
        .out_data  (outData4),
        .out_phase (outPhase4),
        .level     (level4),
        .pair_cnt  (pairCnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] e,
                                 input logic [7:0] o, input logic r);
        inValid  = v;
        yEven    = e;
        yOdd     = o;
        outReady = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp4 [4];
        logic       stall [9];
        int         accepted;
        int         idx;

        exp4[0] = 8'h31; exp4[1] = 8'h32; exp4[2] = 8'h33; exp4[3] = 8'h34;
        stall[0] = 1'b0; stall[1] = 1'b0; stall[2] = 1'b1; stall[3] = 1'b0;
        stall[4] = 1'b0; stall[5] = 1'b1; stall[6] = 1'b1; stall[7] = 1'b0;
        stall[8] = 1'b1;

        // Reset values
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_out_data",  32'(outData),  32'd0);
        checkOutput("rst_out_phase", 32'(outPhase), 32'd0);
        checkOutput("rst_level",     32'(level),    32'd0);
        checkOutput("rst_pair_cnt",  32'(pairCnt),  32'd0);
        checkOutput("rst_in_ready",  32'(inReady),  32'd1);
        rst = 1'b1;
        tick();

        // Single pair 11/22 with out_ready high
        applyStimulus(1'b1, 8'h11, 8'h22, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
        checkOutput("single_lat_valid", 32'(outValid), 32'd0);
        checkOutput("single_lat_level", 32'(level),    32'd1);
        tick();
        checkOutput("single_even_valid", 32'(outValid), 32'd1);
        checkOutput("single_even_data",  32'(outData),  32'h11);
        checkOutput("single_even_phase", 32'(outPhase), 32'd0);
        checkOutput("single_level0",     32'(level),    32'd0);
        tick();
        checkOutput("single_odd_data",  32'(outData),  32'h22);
        checkOutput("single_odd_phase", 32'(outPhase), 32'd1);
        tick();
        checkOutput("single_done_valid", 32'(outValid), 32'd0);
        checkOutput("single_pair_cnt",   32'(pairCnt),  32'd1);

        // Back-to-back pairs at one pair per two cycles: 01..06 contiguous
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0 && c < 6)
                applyStimulus(1'b1, 8'(c + 1), 8'(c + 2), 1'b1);
            else
                applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
            checkOutput("b2b_in_ready", 32'(inReady), 32'd1);
            tick();
            if (c >= 1 && c <= 6) begin
                checkOutput("b2b_valid", 32'(outValid), 32'd1);
                checkOutput("b2b_data",  32'(outData),  32'(c));
                checkOutput("b2b_phase", 32'(outPhase), 32'((c - 1) % 2));
            end
        end
        checkOutput("b2b_idle_valid", 32'(outValid), 32'd0);
        checkOutput("b2b_pair_cnt",   32'(pairCnt),  32'd4);

        // Fill with out_ready low: DEPTH+1 pairs accepted
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 8'(8'h20 + 2 * accepted), 8'(8'h21 + 2 * accepted), 1'b0);
            if (inReady) accepted++;
            tick();
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("fill_accepted", 32'(accepted), 32'd5);
        checkOutput("fill_level",    32'(level),    32'd4);
        checkOutput("fill_in_ready", 32'(inReady),  32'd0);
        checkOutput("fill_valid",    32'(outValid), 32'd1);
        checkOutput("fill_head",     32'(outData),  32'h20);
        outReady = 1'b1;
        for (int s = 1; s < 10; s++) begin
            tick();
            checkOutput("drain_valid", 32'(outValid), 32'd1);
            checkOutput("drain_data",  32'(outData),  32'(8'h20 + s));
            checkOutput("drain_phase", 32'(outPhase), 32'(s % 2));
            if (s == 1) checkOutput("drain_ready_low", 32'(inReady), 32'd0);
            if (s == 2) checkOutput("drain_ready_up",  32'(inReady), 32'd1);
        end
        tick();
        checkOutput("drain_idle",     32'(outValid), 32'd0);
        checkOutput("drain_level",    32'(level),    32'd0);
        checkOutput("drain_pair_cnt", 32'(pairCnt),  32'd9);

        // Stalls during EVEN and ODD: payload holds until accepted
        applyStimulus(1'b1, 8'h31, 8'h32, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h33, 8'h34, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            outReady = stall[c];
            checkOutput("stall_valid", 32'(outValid), 32'd1);
            checkOutput("stall_data",  32'(outData),  32'(exp4[idx]));
            checkOutput("stall_phase", 32'(outPhase), 32'(idx % 2));
            if (stall[c]) idx++;
            tick();
        end
        checkOutput("stall_idle",     32'(outValid), 32'd0);
        checkOutput("stall_pair_cnt", 32'(pairCnt),  32'd11);

        // Asynchronous reset while in ODD with two pairs queued
        applyStimulus(1'b1, 8'h41, 8'h42, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h43, 8'h44, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h45, 8'h46, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        outReady = 1'b0;
        checkOutput("mid_odd_data",  32'(outData),  32'h42);
        checkOutput("mid_odd_phase", 32'(outPhase), 32'd1);
        checkOutput("mid_level",     32'(level),    32'd2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_valid",    32'(outValid), 32'd0);
        checkOutput("arst_data",     32'(outData),  32'd0);
        checkOutput("arst_level",    32'(level),    32'd0);
        checkOutput("arst_pair_cnt", 32'(pairCnt),  32'd0);
        checkOutput("arst_in_ready", 32'(inReady),  32'd1);
        applyStimulus(1'b1, 8'h55, 8'h66, 1'b1);
        tick();
        tick();
        checkOutput("arst_push_ignored", 32'(level), 32'd0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
        rst = 1'b1;
        tick();
        applyStimulus(1'b1, 8'hAA, 8'hBB, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("post_even_data", 32'(outData),  32'hAA);
        checkOutput("post_even_phase", 32'(outPhase), 32'd0);
        tick();
        checkOutput("post_odd_data", 32'(outData), 32'hBB);
        tick();
        checkOutput("post_idle",     32'(outValid), 32'd0);
        checkOutput("post_pair_cnt", 32'(pairCnt),  32'd1);

        // CW=4 counter wrap: 15, then 0, then 1
        for (int n = 0; n < 14; n++) begin
            applyStimulus(1'b1, 8'(n), 8'(n + 8'h80), 1'b1);
            tick();
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
            tick();
            tick();
            tick();
        end
        checkOutput("wrap_cnt4_15",  32'(pairCnt4), 32'd15);
        checkOutput("wrap_cnt16_15", 32'(pairCnt),  32'd15);
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1'b1, 8'hC0, 8'hC1, 1'b1);
            tick();
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
            tick();
            tick();
            tick();
            if (n == 0) begin
                checkOutput("wrap_cnt4_0",   32'(pairCnt4), 32'd0);
                checkOutput("wrap_cnt16_16", 32'(pairCnt),  32'd16);
            end else begin
                checkOutput("wrap_cnt4_1",   32'(pairCnt4), 32'd1);
                checkOutput("wrap_cnt16_17", 32'(pairCnt),  32'd17);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
